// File: rtl/wide_add_pkg.sv
// ----------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the wide-operand add sequencer.
//   LIMB_W  : width of one limb handled by the 16-bit adder per cycle
//   state_t : FSM state encoding (IDLE, RUN, DONE)
// ----------------------------------------------------------------------------
package wide_add_pkg;

    localparam int unsigned LIMB_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/adder_16bit.sv
// ----------------------------------------------------------------------------
// adder_16bit
// Combinational 16-bit two's-complement adder.
//   a, b     : operands
//   cin      : carry-in
//   sum      : (a + b + cin) mod 2^16
//   cout     : carry out of bit 15
//   overflow : signed overflow (operands share a sign that the result lacks)
// ----------------------------------------------------------------------------
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        overflow
);

    logic [16:0] full;

    always_comb begin
        full     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        sum      = full[15:0];
        cout     = full[16];
        overflow = (a[15] == b[15]) && (full[15] != a[15]);
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// ----------------------------------------------------------------------------
// wide_add_sequencer
// Multi-cycle wide adder built on one adder_16bit. An accepted operand pair is
// added one 16-bit limb per cycle, least-significant limb first, with the
// carry chained through a register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   op_a, op_b, cin     : W-bit operands and carry-in, W = 16*WORDS
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout, overflow : full-width sum, carry out, signed overflow
// ----------------------------------------------------------------------------
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*WORDS-1:0] op_a,
    input  logic [LIMB_W*WORDS-1:0] op_b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    overflow
);

    localparam int unsigned W     = LIMB_W * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [LIMB_W-1:0] limb_a, limb_b, limb_sum;
    logic              limb_cout, limb_ovf;
    logic              last_limb;

    // Select the current limb of each latched operand.
    always_comb begin
        limb_a = '0;
        limb_b = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                limb_a = a_q[i*LIMB_W +: LIMB_W];
                limb_b = b_q[i*LIMB_W +: LIMB_W];
            end
        end
    end

    adder_16bit u_adder (
        .a        (limb_a),
        .b        (limb_b),
        .cin      (carry_q),
        .sum      (limb_sum),
        .cout     (limb_cout),
        .overflow (limb_ovf)
    );

    assign last_limb = (idx_q == IDX_W'(WORDS - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*LIMB_W +: LIMB_W] = limb_sum;
                    end
                end
                carry_d = limb_cout;
                idx_d   = idx_q + 1'b1;
                // Only the top limb's carry and overflow describe the full-width add.
                if (last_limb) begin
                    cout_d  = limb_cout;
                    ovf_d   = limb_ovf;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags are pure state decodes.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// ----------------------------------------------------------------------------
// tb_wide_add_sequencer
// Self-checking bench for wide_add_sequencer with WORDS = 4.
// ----------------------------------------------------------------------------
module tb_wide_add_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    int acc_n  = 0;
    int cyc    = 0;
    int acc_cyc[$];

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[6];

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Acceptance monitor: sees pre-edge values of in_valid/in_ready.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && in_valid && in_ready) begin
            acc_n = acc_n + 1;
            acc_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for its result, check latency and fields.
    task automatic do_op(input vec_t v);
        int n0;
        int lat;
        bit got;
        @(negedge clk);
        op_a      = v.a;
        op_b      = v.b;
        cin       = v.ci;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n0  = acc_n;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (acc_n != n0) begin
                got = 1'b1;
                break;
            end
        end
        chk({v.name, " accepted"}, W'(got), W'(1));
        in_valid = 1'b0;
        // Scramble inputs: result must come from latched operands.
        op_a = ~v.a;
        op_b = ~v.b;
        cin  = ~v.ci;
        lat  = 0;
        got  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({v.name, " latency"}, W'(lat), W'(4));
        chk({v.name, " sum"}, sum, v.exp_sum);
        chk({v.name, " cout"}, W'(cout), W'(v.exp_cout));
        chk({v.name, " overflow"}, W'(overflow), W'(v.exp_ovf));
        @(posedge clk);
        #1;
        chk({v.name, " back to idle"}, W'(in_ready), W'(1));
    endtask

    initial begin
        vec_t v;
        int   n0;
        bit   seen;

        vecs[0] = '{"ripple", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{"wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                    64'h0, 1'b1, 1'b0};
        vecs[2] = '{"pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{"neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                    64'h0, 1'b1, 1'b1};
        vecs[4] = '{"low_limb_ovf", 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[5] = '{"mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                    64'h2222_2222_2222_2212, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", W'(in_ready), W'(1));
        chk("reset out_valid", W'(out_valid), W'(0));
        chk("reset sum", sum, 64'h0);
        chk("reset cout", W'(cout), W'(0));
        chk("reset overflow", W'(overflow), W'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i]);
        end

        // Backpressure: hold the result, offer a second op that must wait.
        @(negedge clk);
        out_ready = 1'b0;
        op_a      = vecs[2].a;
        op_b      = vecs[2].b;
        cin       = vecs[2].ci;
        in_valid  = 1'b1;
        n0 = acc_n;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (acc_n != n0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp first accepted", W'(seen), W'(1));
        // Second operation offered while busy.
        op_a = vecs[5].a;
        op_b = vecs[5].b;
        cin  = vecs[5].ci;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp out_valid", W'(seen), W'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp held out_valid", W'(out_valid), W'(1));
            chk("bp held sum", sum, vecs[2].exp_sum);
            chk("bp held cout", W'(cout), W'(vecs[2].exp_cout));
            chk("bp held overflow", W'(overflow), W'(vecs[2].exp_ovf));
            chk("bp in_ready low", W'(in_ready), W'(0));
        end
        chk("bp no second accept", W'(acc_n), W'(n0 + 1));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp idle after release", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        chk("bp second accepted", W'(acc_n), W'(n0 + 2));
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp second out_valid", W'(seen), W'(1));
        chk("bp second sum", sum, vecs[5].exp_sum);
        @(posedge clk);
        #1;

        // Back-to-back issue interval with out_ready high.
        @(negedge clk);
        op_a      = vecs[0].a;
        op_b      = vecs[0].b;
        cin       = vecs[0].ci;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n0 = acc_n;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (acc_n == n0 + 2) begin
                seen = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("interval two accepts", W'(seen), W'(1));
        if (seen) begin
            chk("issue interval", W'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]),
                W'(6));
        end
        repeat (8) @(posedge clk);

        // Reset after two limbs have been processed.
        @(negedge clk);
        op_a     = vecs[5].a;
        op_b     = vecs[5].b;
        cin      = vecs[5].ci;
        in_valid = 1'b1;
        n0 = acc_n;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (acc_n != n0) break;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst mid in_ready", W'(in_ready), W'(1));
        chk("rst mid out_valid", W'(out_valid), W'(0));
        chk("rst mid sum", sum, 64'h0);
        chk("rst mid cout", W'(cout), W'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst mid no out_valid", W'(seen), W'(0));
        v = vecs[3];
        v.name = "after_reset";
        do_op(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide-operand adder that sits directly upstream of `adder_16bit` and also consumes its output. It accepts a `16*WORDS`-bit operand pair over a valid/ready handshake and feeds the 16-bit adder one limb per cycle, least-significant limb first. Carry is chained between limbs through a register, and the assembled sum, final carry and signed overflow are presented on a valid/ready output. It gives the datapath 32/64-bit addition while reusing the existing 16-bit adder.

## Interface
Parameters:
- `WORDS`, default 4: number of 16-bit limbs; legal range ≥ 1; operand width `W = 16*WORDS`.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand pair and `cin` are valid.
- `in_ready`  out  1: block can accept an operation; high only in `IDLE`.
- `op_a`  in  W: operand A, two's complement.
- `op_b`  in  W: operand B, two's complement.
- `cin`  in  1: carry-in to limb 0.
- `out_valid`  out  1: result fields valid; high only in `DONE`.
- `out_ready`  in  1: consumer accepts the result.
- `sum`  out  W: `(op_a + op_b + cin) mod 2^W`.
- `cout`  out  1: carry out of bit `W-1`.
- `overflow`  out  1: signed overflow of the full-width add.

## Operation
- FSM states:
  - `IDLE`: `in_ready=1`. If `in_valid` is high, latch `op_a`, `op_b`, carry register ← `cin`, limb index ← 0, clear `sum`, go to `RUN`.
  - `RUN`: the adder is driven combinationally with limb `idx` of A and B and the carry register.
    - Each cycle: `sum[16*idx +: 16]` ← adder sum, carry register ← adder cout, `idx` ← `idx+1`.
    - When `idx == WORDS-1`: `cout` ← adder cout, `overflow` ← adder overflow (top limb only), go to `DONE`.
  - `DONE`: `out_valid=1`; `sum`, `cout` and `overflow` are held stable. If `out_ready` is high, go to `IDLE`.
- Latched operands are used during `RUN`. Changes on `op_a`, `op_b` or `cin` after acceptance have no effect.
- `overflow` and `cout` come only from the top limb. Lower-limb adder overflow is ignored.
- `in_valid` seen outside `IDLE` is ignored; the upstream holds it until `in_ready`.
- `WORDS=1`: a single `RUN` cycle; behaves as a registered `adder_16bit`.

## Timing
- Acceptance at rising edge `k` (`in_valid && in_ready`).
- `RUN` occupies edges `k+1` … `k+WORDS`.
- `out_valid` rises after edge `k+WORDS`: latency is `WORDS` cycles from acceptance to `out_valid`.
- Minimum issue interval is `WORDS+2` cycles: 1 `IDLE`, `WORDS` `RUN`, 1 `DONE` with `out_ready` held high.
- Backpressure: `DONE` persists indefinitely while `out_ready` is low. Outputs stay stable and `in_ready` stays 0.
- Reset values, after any edge with `rst=1`:
  - state `IDLE`, `in_ready=1`, `out_valid=0`;
  - `sum=0`, `cout=0`, `overflow=0`;
  - limb index 0, carry register 0.
- `rst` overrides any simultaneous handshake.
- Reset mid-operation (in `RUN` or `DONE`) discards the operation; no `out_valid` is produced for it.
- `in_ready` and `out_valid` are pure state decodes, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `wide_add_pkg`:
  - `LIMB_W = 16`;
  - state enum `{IDLE, RUN, DONE}`.
- Limb index width is `$clog2(WORDS)`, minimum 1 bit.
- Sub-module: one instance of the existing `adder_16bit` (ports `a`, `b`, `cin`, `sum`, `cout`, `overflow`). No other sub-modules.
- Expected size is about 150 lines of RTL.

## Test plan
All scenarios use `WORDS=4`.
1. Carry ripple: A=`0x0000_0000_0000_FFFF`, B=`0x1`, cin=0 → sum=`0x0000_0000_0001_0000`, cout=0, overflow=0; `out_valid` exactly 4 cycles after acceptance.
2. Full wrap: A=`0xFFFF_FFFF_FFFF_FFFF`, B=0, cin=1 → sum=0, cout=1, overflow=0.
3. Positive overflow: A=`0x7FFF_FFFF_FFFF_FFFF`, B=1, cin=0 → sum=`0x8000_0000_0000_0000`, cout=0, overflow=1.
4. Negative overflow: A=B=`0x8000_0000_0000_0000`, cin=0 → sum=0, cout=1, overflow=1; a lower-limb-only case A=B=`0x0000_0000_0000_8000` gives sum=`0x1_0000`, overflow=0.
5. Backpressure:
   - Hold `out_ready=0` for 5 cycles after `out_valid`: sum, cout and overflow stay stable, `in_ready=0`, and a second `in_valid` is not accepted.
   - Raise `out_ready`: `IDLE` follows next cycle and the second operation is accepted, giving an issue interval of exactly 6 cycles with `out_ready` high.
6. Reset mid-`RUN`: pulse `rst` after 2 limbs → no `out_valid`, sum=0, `in_ready=1` on the cycle after the reset edge, and the next operation completes correctly.
